div_issue_ctrl: RTL and testbench

- EX-stage initiator for the iterative divider.
- Takes RV32M DIV/DIVU/REM/REMU requests from the pipeline, latches the operands and issues a one-cycle start.
- Stalls the pipeline until the divider's one-cycle done pulse arrives, then returns the result with its destination register.
- Handles flush, draining of an in-flight division (the divider cannot abort), and a watchdog timeout.

---
 rtl/div_ctrl_pkg.sv | 38 +++
 rtl/div_issue_ctrl.sv | 165 ++++++++++++++++
 tb/tb_div_issue_ctrl.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/div_ctrl_pkg.sv
// Shared constants for the EX-stage divider initiator:
// FSM state encodings, RV32M divide funct3 codes and divider mode codes.
package div_ctrl_pkg;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_RESP  = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE  = S_IDLE,
        ST_ISSUE = S_ISSUE,
        ST_WAIT  = S_WAIT,
        ST_RESP  = S_RESP,
        ST_DRAIN = S_DRAIN
    } state_t;

    localparam logic [2:0] F3_DIV  = 3'b100;
    localparam logic [2:0] F3_DIVU = 3'b101;
    localparam logic [2:0] F3_REM  = 3'b110;
    localparam logic [2:0] F3_REMU = 3'b111;

    localparam logic [1:0] MODE_DIV  = 2'b00;
    localparam logic [1:0] MODE_DIVU = 2'b01;
    localparam logic [1:0] MODE_REM  = 2'b10;
    localparam logic [1:0] MODE_REMU = 2'b11;

    function automatic logic [1:0] f3_to_mode(input logic [2:0] f3);
        case (f3)
            F3_DIVU: return MODE_DIVU;
            F3_REM:  return MODE_REM;
            F3_REMU: return MODE_REMU;
            default: return MODE_DIV;
        endcase
    endfunction

endpackage

// File: rtl/div_issue_ctrl.sv
// EX-stage initiator for the iterative RV32M divider, with drain and watchdog.
// Optional one-entry result cache enabled by defining DIV_RESULT_CACHE_EN.
module div_issue_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 40,
    parameter int XLEN           = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_rs1,
    input  logic [XLEN-1:0] req_rs2,
    input  logic [4:0]      req_rd,
    input  logic            flush,
    output logic            stall,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_data,
    output logic [4:0]      resp_rd,
    output logic            err,
    output logic            div_start,
    output logic [XLEN-1:0] div_dividend,
    output logic [XLEN-1:0] div_divisor,
    output logic [1:0]      div_mode,
    input  logic [XLEN-1:0] div_result,
    input  logic            div_done
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [XLEN-1:0] rs1_q;
    logic [XLEN-1:0] rs2_q;
    logic [XLEN-1:0] res_q;
    logic [4:0]      rd_q;
    logic [1:0]      mode_q;
    logic [1:0]      req_mode;
    logic            accept;
    logic            tmo;
    logic            hit;
    logic [XLEN-1:0] hit_res;

    assign req_mode = f3_to_mode(req_funct3);
    assign accept   = req_valid & ~flush;
    assign tmo      = (cnt_q == CW'(TIMEOUT_CYCLES));

`ifdef DIV_RESULT_CACHE_EN
    logic            c_vld;
    logic [XLEN-1:0] c_rs1;
    logic [XLEN-1:0] c_rs2;
    logic [XLEN-1:0] c_res;
    logic [1:0]      c_mode;

    assign hit = c_vld && (c_rs1 == req_rs1) && (c_rs2 == req_rs2)
                 && (c_mode == req_mode);
    assign hit_res = c_res;

    // Only genuine divider results are remembered, never timeouts or drains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_vld  <= 1'b0;
            c_rs1  <= '0;
            c_rs2  <= '0;
            c_res  <= '0;
            c_mode <= '0;
        end else if (state_q == ST_WAIT && div_done) begin
            c_vld  <= 1'b1;
            c_rs1  <= rs1_q;
            c_rs2  <= rs2_q;
            c_res  <= div_result;
            c_mode <= mode_q;
        end
    end
`else
    assign hit     = 1'b0;
    assign hit_res = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            res_q   <= '0;
            rd_q    <= '0;
            mode_q  <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        rs1_q  <= req_rs1;
                        rs2_q  <= req_rs2;
                        rd_q   <= req_rd;
                        mode_q <= req_mode;
                        if (hit) begin
                            res_q   <= hit_res;
                            state_q <= ST_RESP;
                        end else begin
                            state_q <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    cnt_q <= '0;
                    if (flush) state_q <= ST_IDLE;
                    else       state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    cnt_q <= cnt_q + CW'(1);
                    if (div_done) begin
                        res_q   <= div_result;
                        state_q <= ST_RESP;
                    end else if (tmo) begin
                        res_q   <= '0;
                        state_q <= ST_RESP;
                    end else if (flush) begin
                        cnt_q   <= '0;
                        state_q <= ST_DRAIN;
                    end
                end
                ST_RESP: state_q <= ST_IDLE;
                // The divider cannot abort, so wait out its done pulse.
                ST_DRAIN: begin
                    cnt_q <= cnt_q + CW'(1);
                    if (div_done || tmo) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        stall      = 1'b0;
        resp_valid = 1'b0;
        err        = 1'b0;
        div_start  = 1'b0;
        unique case (state_q)
            ST_IDLE:  stall = accept;
            ST_ISSUE: begin
                stall     = 1'b1;
                div_start = ~flush;
            end
            ST_WAIT: begin
                stall = 1'b1;
                err   = tmo & ~div_done;
            end
            ST_RESP:  resp_valid = ~flush;
            ST_DRAIN: begin
                stall = req_valid;
                err   = tmo & ~div_done;
            end
            default: ;
        endcase
    end

    assign resp_data    = res_q;
    assign resp_rd      = rd_q;
    assign div_dividend = rs1_q;
    assign div_divisor  = rs2_q;
    assign div_mode     = mode_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Bench for div_issue_ctrl: timeline model of each divide plus a
// behavioural divider, checked every cycle, with pinned literal latencies.
module tb_div_issue_ctrl;
    import div_ctrl_pkg::*;

    localparam int XLEN = 32;
    localparam int TMO  = 40;
    localparam int N    = 1024;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            req_valid = 1'b0;
    logic [2:0]      req_funct3 = '0;
    logic [XLEN-1:0] req_rs1 = '0;
    logic [XLEN-1:0] req_rs2 = '0;
    logic [4:0]      req_rd = '0;
    logic            flush = 1'b0;
    logic            stall;
    logic            resp_valid;
    logic [XLEN-1:0] resp_data;
    logic [4:0]      resp_rd;
    logic            err;
    logic            div_start;
    logic [XLEN-1:0] div_dividend;
    logic [XLEN-1:0] div_divisor;
    logic [1:0]      div_mode;
    logic [XLEN-1:0] div_result = '0;
    logic            div_done = 1'b0;

    div_issue_ctrl #(.TIMEOUT_CYCLES(TMO), .XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_funct3(req_funct3),
        .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd),
        .flush(flush), .stall(stall),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_rd(resp_rd),
        .err(err), .div_start(div_start),
        .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_mode(div_mode), .div_result(div_result), .div_done(div_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ref_div(input logic [1:0] m,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        logic ovf;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (m)
            2'b00: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return a;
                return $signed(a) / $signed(b);
            end
            2'b01: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            2'b10: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                return $signed(a) % $signed(b);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Behavioural divider: zero divisor finishes next cycle, else 33 cycles.
    bit          stub = 1'b0;
    bit          pend = 1'b0;
    int          done_cyc = 0;
    logic [31:0] pres = '0;

    always @(negedge clk)
        if (rst_n && div_start && !stub) begin
            pend = 1'b1;
            done_cyc = cyc + ((div_divisor == 0) ? 1 : 33);
            pres = ref_div(div_mode, div_dividend, div_divisor);
        end

    always @(negedge rst_n) pend = 1'b0;

    initial forever begin
        @(posedge clk);
        #1;
        div_done = 1'b0;
        div_result = $urandom;
        if (rst_n && pend && cyc == done_cyc) begin
            div_done = 1'b1;
            div_result = pres;
            pend = 1'b0;
        end
    end

    // Expected per-cycle outputs; anything not planned must be low.
    bit          e_stall[N];
    bit          e_start[N];
    bit          e_rv[N];
    bit          e_err[N];
    logic [31:0] e_data[N];
    logic [31:0] e_a[N];
    logic [31:0] e_b[N];
    logic [4:0]  e_rd[N];
    logic [1:0]  e_mode[N];

    bit          cache_on = 1'b0;
    bit          mc_v = 1'b0;
    logic [31:0] mc_a = '0;
    logic [31:0] mc_b = '0;
    logic [31:0] mc_r = '0;
    logic [1:0]  mc_m = '0;

    task automatic plan(input int t, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input bit hang, output int r);
        logic [1:0]  m;
        logic [31:0] res;
        int          d;
        m = f3[1:0];
        if (cache_on && mc_v && mc_a == a && mc_b == b && mc_m == m) begin
            e_stall[t] = 1'b1;
            res = mc_r;
            r = t + 1;
        end else begin
            e_start[t+1] = 1'b1;
            e_a[t+1] = a;
            e_b[t+1] = b;
            e_mode[t+1] = m;
            if (hang) begin
                d = t + 2 + TMO;
                e_err[d] = 1'b1;
                res = '0;
            end else begin
                d = t + 1 + ((b == 0) ? 1 : 33);
                res = ref_div(m, a, b);
                mc_v = 1'b1;
                mc_a = a;
                mc_b = b;
                mc_m = m;
                mc_r = res;
            end
            for (int i = t; i <= d; i++) e_stall[i] = 1'b1;
            r = d + 1;
        end
        e_rv[r] = 1'b1;
        e_data[r] = res;
        e_rd[r] = rd;
    endtask

    task automatic txn(input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd,
                       input bit hang, output int t, output int r);
        t = cyc;
        req_valid = 1'b1;
        req_funct3 = f3;
        req_rs1 = a;
        req_rs2 = b;
        req_rd = rd;
        plan(t, f3, a, b, rd, hang, r);
        while (cyc < r) tick();
        req_valid = 1'b0;
        tick();
    endtask

    int          rv_cyc = 0;
    int          st_cyc = 0;
    int          rv_cnt = 0;
    int          st_cnt = 0;
    int          err_cnt = 0;
    logic [31:0] rv_data = '0;
    logic [4:0]  rv_rd = '0;

    always @(negedge clk)
        if (rst_n && cyc < N) begin
            chk("stall", stall, e_stall[cyc]);
            chk("div_start", div_start, e_start[cyc]);
            chk("resp_valid", resp_valid, e_rv[cyc]);
            chk("err", err, e_err[cyc]);
            if (e_start[cyc]) begin
                chk("div_dividend", div_dividend, e_a[cyc]);
                chk("div_divisor", div_divisor, e_b[cyc]);
                chk("div_mode", div_mode, e_mode[cyc]);
            end
            if (e_rv[cyc]) begin
                chk("resp_data", resp_data, e_data[cyc]);
                chk("resp_rd", resp_rd, e_rd[cyc]);
            end
            if (resp_valid) begin
                rv_cyc = cyc;
                rv_data = resp_data;
                rv_rd = resp_rd;
                rv_cnt++;
            end
            if (div_start) begin
                st_cyc = cyc;
                st_cnt++;
            end
            if (err) err_cnt++;
        end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int t, r, t2, r2, s0, v0, e0;
`ifdef DIV_RESULT_CACHE_EN
        cache_on = 1'b1;
`endif
        #2;
        chk("rst_stall", stall, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_div_start", div_start, 0);
        chk("rst_err", err, 0);
        chk("rst_resp_data", resp_data, 0);
        chk("rst_div_mode", div_mode, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        txn(F3_DIV, 32'hFFFF_FFEC, 32'd3, 5'd5, 1'b0, t, r);
        chk("div_start_lat", st_cyc - t, 1);
        chk("div_resp_lat", rv_cyc - t, 35);
        chk("div_resp_data", rv_data, 32'hFFFF_FFFA);
        chk("div_resp_rd", rv_rd, 5);

        e0 = err_cnt;
        txn(F3_REMU, 32'd7, 32'd0, 5'd9, 1'b0, t, r);
        chk("remu0_resp_lat", rv_cyc - t, 3);
        chk("remu0_resp_data", rv_data, 7);
        chk("remu0_err", err_cnt - e0, 0);

        // Flush in the 10th WAIT cycle, new request queued behind the drain.
        s0 = st_cnt;
        v0 = rv_cnt;
        t = cyc;
        req_valid = 1'b1;
        req_funct3 = F3_DIVU;
        req_rs1 = 32'd100;
        req_rs2 = 32'd7;
        req_rd = 5'd3;
        for (int i = t; i <= t + 11; i++) e_stall[i] = 1'b1;
        e_start[t+1] = 1'b1;
        e_a[t+1] = 32'd100;
        e_b[t+1] = 32'd7;
        e_mode[t+1] = MODE_DIVU;
        while (cyc < t + 11) tick();
        flush = 1'b1;
        req_valid = 1'b0;
        tick();
        flush = 1'b0;
        chk("drain_state", dut.state_q, ST_DRAIN);
        req_valid = 1'b1;
        req_rs1 = 32'd50;
        req_rd = 5'd4;
        for (int i = t + 12; i <= t + 34; i++) e_stall[i] = 1'b1;
        plan(t + 35, F3_DIVU, 32'd50, 32'd7, 5'd4, 1'b0, r2);
        while (cyc < r2) tick();
        req_valid = 1'b0;
        tick();
        chk("drain_resp_count", rv_cnt - v0, 1);
        chk("drain_start_count", st_cnt - s0, 2);
        chk("drain_resp_lat", rv_cyc - t, 70);
        chk("drain_resp_data", rv_data, 7);

        stub = 1'b1;
        e0 = err_cnt;
        txn(F3_DIV, 32'd9, 32'd2, 5'd6, 1'b1, t, r);
        stub = 1'b0;
        chk("tmo_err_count", err_cnt - e0, 1);
        chk("tmo_resp_lat", rv_cyc - t, 43);
        chk("tmo_resp_data", rv_data, 0);
        chk("tmo_idle", dut.state_q, ST_IDLE);

        txn(F3_DIV, 32'd100, 32'd7, 5'd7, 1'b0, t, r);
        chk("b2b1_resp_lat", rv_cyc - t, 35);
        chk("b2b1_resp_data", rv_data, 14);
        s0 = st_cnt;
        txn(F3_DIV, 32'd100, 32'd7, 5'd8, 1'b0, t2, r2);
        chk("b2b2_resp_data", rv_data, 14);
        chk("b2b2_resp_rd", rv_rd, 8);
`ifdef DIV_RESULT_CACHE_EN
        chk("b2b2_resp_lat", rv_cyc - t2, 1);
        chk("b2b2_start_count", st_cnt - s0, 0);
`else
        chk("b2b2_resp_lat", rv_cyc - t2, 35);
        chk("b2b2_start_count", st_cnt - s0, 1);
`endif

        // Stray done while idle must be ignored.
        v0 = rv_cnt;
        #1;
        div_done = 1'b1;
        tick();
        tick();
        chk("stray_done_resp", rv_cnt - v0, 0);

        // Reset in the middle of WAIT.
        t = cyc;
        req_valid = 1'b1;
        req_funct3 = F3_DIV;
        req_rs1 = 32'd1000;
        req_rs2 = 32'd10;
        req_rd = 5'd10;
        for (int i = t; i <= t + 5; i++) e_stall[i] = 1'b1;
        e_start[t+1] = 1'b1;
        e_a[t+1] = 32'd1000;
        e_b[t+1] = 32'd10;
        e_mode[t+1] = MODE_DIV;
        while (cyc < t + 5) tick();
        #1;
        rst_n = 1'b0;
        req_valid = 1'b0;
        mc_v = 1'b0;
        #1;
        chk("rst_mid_stall", stall, 0);
        chk("rst_mid_resp_valid", resp_valid, 0);
        chk("rst_mid_div_start", div_start, 0);
        chk("rst_mid_err", err, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        txn(F3_DIVU, 32'd1000, 32'd10, 5'd11, 1'b0, t, r);
        chk("post_rst_resp_lat", rv_cyc - t, 35);
        chk("post_rst_resp_data", rv_data, 100);
        chk("post_rst_resp_rd", rv_rd, 11);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
